dmem_access_ctrl: RTL and testbench
===================================

# dmem_access_ctrl

Sequencer between the MEM stage and a multi-cycle data memory with a req/ack handshake. It converts the per-instruction MemRead/MemWrite strobes decoded by the main control unit into exactly one memory transaction and holds the pipeline with a stall while that transaction is outstanding. It also flags misaligned accesses and memory timeouts. It sits in the MEM stage, fed from the EX/MEM pipeline register, and returns load data toward MEM/WB.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MAX_WAIT, 255, cycles in WAIT without ack before timeout; range 1..255

Ports:
- clk_i  in  1  clock; all state changes on the rising edge
- rst_n_i  in  1  reset; asynchronous, active-low
- MemRead_i  in  1  load in MEM stage (from EX/MEM)
- MemWrite_i  in  1  store in MEM stage (from EX/MEM)
- addr_i  in  ADDR_W  ALU result, byte address
- wdata_i  in  DATA_W  store data
- mem_req_o  out  1  transaction request to memory
- mem_we_o  out  1  1 = write, 0 = read; valid while mem_req_o is high
- mem_addr_o  out  ADDR_W  registered address
- mem_wdata_o  out  DATA_W  registered store data
- mem_ack_i  in  1  memory completion, one-cycle pulse
- mem_rdata_i  in  DATA_W  read data; valid in the cycle mem_ack_i is high
- rdata_o  out  DATA_W  load result to MEM/WB
- stall_o  out  1  hold PC, IF/ID, ID/EX and EX/MEM
- err_o  out  1  one-cycle pulse: misaligned, conflicting strobes, or timeout

## Operation
States: IDLE, WAIT, DONE.

IDLE:
- stall_o = MemRead_i | MemWrite_i. This output is combinational in IDLE so the pipeline freezes in the same cycle.
- Legal access: exactly one strobe high and addr_i[1:0] == 0.
  - Latch addr_i, wdata_i and we = MemWrite_i.
  - Go to WAIT and clear the wait counter.
- Illegal access: both strobes high, or addr_i[1:0] != 0.
  - No memory request is issued.
  - Go to DONE with the error flag set.
- Neither strobe high: remain in IDLE.

WAIT:
- mem_req_o = 1 and stall_o = 1.
- mem_we_o, mem_addr_o and mem_wdata_o stay stable until ack.
- On mem_ack_i:
  - For a read, capture mem_rdata_i into rdata_o.
  - Go to DONE.
- Without ack, the counter increments each cycle.
- When counter == MAX_WAIT-1 and there is no ack in that cycle, go to DONE with the error flag set. rdata_o is not updated.
- Ack and timeout in the same cycle: ack wins, no error.

DONE:
- Lasts exactly one cycle. stall_o = 0 and mem_req_o = 0.
- err_o = the error flag (registered).
- The pipeline advances at the end of this cycle.
- MemRead_i/MemWrite_i are ignored here, because they still belong to the completed instruction.
- Always returns to IDLE.

Other rules:
- rdata_o holds its value until the next successful read. Writes, errors and timeouts never change it.
- mem_ack_i outside WAIT is ignored.

## Timing
- Reset (rst_n_i low, asynchronous) drives state to IDLE and clears:
  - mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  - rdata_o, err_o
  - the wait counter
- stall_o then follows the IDLE rule.
- Reset during WAIT drops mem_req_o immediately, without waiting for the clock. A late ack after reset is ignored.
- Legal access with ack k cycles after mem_req_o rises (k ≥ 0, i.e. ack in the first WAIT cycle):
  - IDLE for 1 cycle, WAIT for k+1 cycles, DONE for 1 cycle.
  - stall_o is high for k+2 cycles.
- Illegal access: IDLE (stall) for 1 cycle, then DONE (err_o = 1) for 1 cycle. mem_req_o is never asserted.
- Timeout: exactly MAX_WAIT cycles of mem_req_o high, then DONE with err_o = 1.
- Back-to-back memory instructions: a new request is accepted in the IDLE cycle immediately after DONE. There are no idle bubbles beyond that.
- All outputs except stall_o are registered.

## Test plan
- Reset: hold rst_n_i = 0 for 3 cycles with MemRead_i = 1 → mem_req_o = 0, rdata_o = 0, err_o = 0. After release: stall_o = 1, and the access proceeds.
- Zero-wait load: MemRead_i = 1, addr_i = 0x10, ack in the first WAIT cycle with mem_rdata_i = 0xDEADBEEF → mem_req_o high for 1 cycle, stall_o high for 2 cycles, rdata_o = 0xDEADBEEF in DONE.
- Store with 3-cycle ack delay: MemWrite_i = 1, addr_i = 0x20, wdata_i = 0x12345678 → mem_we_o = 1 and mem_wdata_o = 0x12345678 stable for 4 cycles, stall_o high for 5 cycles, rdata_o unchanged.
- Misaligned load: addr_i = 0x22 → no mem_req_o, stall_o high for 1 cycle, err_o = 1 for 1 cycle. Repeat with MemRead_i = MemWrite_i = 1 → same response.
- Timeout with MAX_WAIT = 4 and no ack → mem_req_o high for exactly 4 cycles, then err_o pulse and stall_o = 0. Variant with ack in the 4th cycle → no error.
- Reset mid-WAIT after 2 cycles, then a spurious ack → mem_req_o falls asynchronously, the ack is ignored, state is IDLE.

Source files
------------

// File: rtl/dmem_access_ctrl.sv
// MEM-stage sequencer for a multi-cycle data memory: one req/ack transaction per
// load/store, pipeline stall while it is outstanding, error pulse on misalignment or timeout.
module dmem_access_ctrl #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              stall_o,
  output logic              err_o
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_e;

  localparam logic [7:0] LAST_WAIT = 8'(MAX_WAIT - 1);

  state_e              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                req_q, req_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = 1'b0;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = 1'b0;
    stall_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        stall_o = MemRead_i | MemWrite_i;
        if ((MemRead_i ^ MemWrite_i) && (addr_i[1:0] == 2'b00)) begin
          we_d    = MemWrite_i;
          addr_d  = addr_i;
          wdata_d = wdata_i;
          cnt_d   = '0;
          req_d   = 1'b1;
          state_d = WAIT;
        end else if (MemRead_i | MemWrite_i) begin
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      WAIT: begin
        stall_o = 1'b1;
        // ack has priority over the timeout in the final wait cycle
        if (mem_ack_i) begin
          if (!we_q) rdata_d = mem_rdata_i;
          state_d = DONE;
        end else if (cnt_q == LAST_WAIT) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
          req_d = 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign mem_req_o   = req_q;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign rdata_o     = rdata_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed and randomized transaction-level checks of dmem_access_ctrl with a short timeout.
module tb_dmem_access_ctrl;

  localparam int unsigned MW = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_read, mem_write;
  logic [31:0] addr, wdata;
  logic        req, we;
  logic [31:0] maddr, mwdata;
  logic        ack;
  logic [31:0] mrdata, rdata;
  logic        stall, err;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [31:0] exp_rdata;

  always #5 clk = ~clk;

  dmem_access_ctrl #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(MW)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .MemRead_i(mem_read), .MemWrite_i(mem_write),
    .addr_i(addr), .wdata_i(wdata),
    .mem_req_o(req), .mem_we_o(we), .mem_addr_o(maddr), .mem_wdata_o(mwdata),
    .mem_ack_i(ack), .mem_rdata_i(mrdata),
    .rdata_o(rdata), .stall_o(stall), .err_o(err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Each cycle: drive inputs at the falling edge, check 1 time unit later.
  // Strobes stay asserted through DONE, as the pipeline only advances then.
  task automatic txn(input logic rd, input logic wr, input logic [31:0] a,
                     input logic [31:0] wd, input int delay, input logic [31:0] rdv);
    logic [1:0] low;
    bit legal, tout;
    int nwait;
    logic [31:0] rv;
    low   = a[1:0];
    legal = (rd ^ wr) && (low == 2'b00);
    mem_read = rd; mem_write = wr; addr = a; wdata = wd; ack = 1'b0;
    #1;
    check("idle_stall", stall, 1);
    check("idle_req", req, 0);
    check("idle_err", err, 0);
    @(negedge clk);
    if (!legal) begin
      #1;
      check("ill_req", req, 0);
      check("ill_stall", stall, 0);
      check("ill_err", err, 1);
      check("ill_rdata", rdata, exp_rdata);
      @(negedge clk);
    end else begin
      tout  = (delay < 0) || (delay >= int'(MW));
      nwait = tout ? int'(MW) : delay + 1;
      for (int w = 0; w < nwait; w++) begin
        ack = (!tout && w == delay);
        rv  = ack ? rdv : $urandom;
        mrdata = rv;
        #1;
        check("wait_req", req, 1);
        check("wait_stall", stall, 1);
        check("wait_we", we, wr);
        check("wait_addr", maddr, a);
        check("wait_wdata", mwdata, wd);
        check("wait_err", err, 0);
        if (ack && rd) exp_rdata = rv;
        @(negedge clk);
      end
      ack = 1'b0;
      #1;
      check("done_stall", stall, 0);
      check("done_req", req, 0);
      check("done_err", err, tout);
      check("done_rdata", rdata, exp_rdata);
      @(negedge clk);
    end
  endtask

  // Cycle with no memory instruction; a stray ack must be ignored.
  task automatic idle_cycle();
    mem_read = 1'b0; mem_write = 1'b0; ack = 1'b1; mrdata = $urandom;
    #1;
    check("nop_stall", stall, 0);
    check("nop_req", req, 0);
    check("nop_err", err, 0);
    @(negedge clk);
    ack = 1'b0;
    #1;
    check("nop_rdata", rdata, exp_rdata);
  endtask

  initial begin
    logic [31:0] r, a;
    int kind, dly;
    rst_n = 1'b0; mem_read = 1'b1; mem_write = 1'b0;
    addr = 32'h10; wdata = '0; ack = 1'b0; mrdata = '0;
    exp_rdata = '0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("rst_req", req, 0);
      check("rst_rdata", rdata, 0);
      check("rst_err", err, 0);
      check("rst_stall", stall, 1);
      @(negedge clk);
    end
    rst_n = 1'b1;

    txn(1, 0, 32'h10, 32'h0, 0, 32'hDEADBEEF);
    txn(0, 1, 32'h20, 32'h12345678, 3, 32'h0);
    txn(1, 0, 32'h22, 32'h0, 0, 32'h0);
    txn(1, 1, 32'h20, 32'h0, 0, 32'h0);
    txn(1, 0, 32'h40, 32'h0, -1, 32'h0);
    txn(1, 0, 32'h44, 32'h0, MW - 1, 32'hCAFEF00D);
    idle_cycle();

    // Reset while a read is outstanding, then an ack that arrives too late.
    mem_read = 1'b1; mem_write = 1'b0; addr = 32'h80; ack = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      #1;
      check("pre_rst_req", req, 1);
      @(negedge clk);
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("async_req_drop", req, 0);
    exp_rdata = '0;
    mem_read = 1'b0; ack = 1'b1; mrdata = 32'hBADBAD00;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("late_ack_req", req, 0);
    check("late_ack_rdata", rdata, 0);
    @(negedge clk);
    #1;
    check("post_rst_stall", stall, 0);
    check("post_rst_req", req, 0);
    check("post_rst_rdata", rdata, 0);
    ack = 1'b0;
    @(negedge clk);

    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 9);
      r    = $urandom;
      a    = $urandom;
      dly  = $urandom_range(0, 5);
      case (kind)
        0, 1, 2, 3: txn(1, 0, {a[31:2], 2'b00}, r, dly, $urandom);
        4, 5, 6:    txn(0, 1, {a[31:2], 2'b00}, r, dly, $urandom);
        7:          txn(a[31], ~a[31], {a[31:2], (a[1:0] == 2'b00) ? 2'b01 : a[1:0]}, r, dly, 32'h0);
        8:          txn(1, 1, {a[31:2], 2'b00}, r, dly, 32'h0);
        default: begin
          idle_cycle();
          @(negedge clk);
        end
      endcase
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
